recons_block_scheduler: RTL and testbench



---
 rtl/recons_block_scheduler.sv | 159 +++++++++++++++
 tb/tb_recons_block_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/recons_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : recons_block_scheduler
// Description : Runs one reconstruction-core pass per image block.
//               Gathers a serial stream of measurements into a zero-filled
//               bank, pulses the core start, waits (bounded) for the core to
//               finish, snapshots its pixels and streams them out under
//               valid/ready.
// Ports       : clk          - rising-edge clock
//               reset        - asynchronous, active-low reset
//               meas_*       - measurement input stream (valid/ready/last)
//               meas_bank    - flattened measurement bank to the core
//               recons_start - one-cycle core start pulse
//               recons_done  - core finish flag (honoured only while waiting)
//               pix_bank     - flattened core pixel outputs
//               pix_*        - pixel output stream (valid/ready/last)
//               block_count  - completed blocks (wrapping)
//               busy         - block in progress
//               err_timeout  - sticky core timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module recons_block_scheduler #(
  parameter int NUM_MEAS = 48,
  parameter int MEAS_W   = 16,
  parameter int NUM_PIX  = 64,
  parameter int PIX_W    = 8,
  parameter int TIMEOUT  = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       meas_valid,
  output logic                       meas_ready,
  input  logic [MEAS_W-1:0]          meas_data,
  input  logic                       meas_last,
  output logic [NUM_MEAS*MEAS_W-1:0] meas_bank,
  output logic                       recons_start,
  input  logic                       recons_done,
  input  logic [NUM_PIX*PIX_W-1:0]   pix_bank,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [PIX_W-1:0]           pix_data,
  output logic                       pix_last,
  output logic [15:0]                block_count,
  output logic                       busy,
  output logic                       err_timeout
);

  localparam int IDX_W  = $clog2(NUM_MEAS);
  localparam int PIDX_W = $clog2(NUM_PIX);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] c_load  = 2'd0;
  localparam logic [1:0] c_start = 2'd1;
  localparam logic [1:0] c_wait  = 2'd2;
  localparam logic [1:0] c_drain = 2'd3;

  localparam logic [IDX_W-1:0]  c_last_meas = IDX_W'(NUM_MEAS - 1);
  localparam logic [PIDX_W-1:0] c_last_pix  = PIDX_W'(NUM_PIX - 1);
  localparam logic [CNT_W-1:0]  c_cnt_max   = CNT_W'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [PIDX_W-1:0] r_pidx;
  logic [CNT_W-1:0]  r_cnt;
  logic [MEAS_W-1:0] r_bank [NUM_MEAS];
  logic [PIX_W-1:0]  r_pix  [NUM_PIX];
  logic [15:0]       r_block_count;
  logic              r_err;
  // Goes high on the first clock after reset release so meas_ready stays
  // low for as long as reset is held, even though the state already reads LOAD.
  logic              r_run;

  logic w_meas_fire;
  logic w_pix_fire;

  assign meas_ready   = r_run && (r_state == c_load);
  assign w_meas_fire  = meas_valid && meas_ready;
  assign recons_start = (r_state == c_start);
  assign pix_valid    = (r_state == c_drain);
  assign w_pix_fire   = pix_valid && pix_ready;
  assign pix_data     = r_pix[r_pidx];
  assign pix_last     = pix_valid && (r_pidx == c_last_pix);
  assign block_count  = r_block_count;
  assign err_timeout  = r_err;
  assign busy         = (r_state != c_load) || (r_idx != '0);

  always_comb begin
    meas_bank = '0;
    for (int i = 0; i < NUM_MEAS; i++) begin
      meas_bank[i*MEAS_W +: MEAS_W] = r_bank[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= c_load;
      r_idx         <= '0;
      r_pidx        <= '0;
      r_cnt         <= '0;
      r_block_count <= '0;
      r_err         <= 1'b0;
      r_run         <= 1'b0;
      for (int i = 0; i < NUM_MEAS; i++) r_bank[i] <= '0;
      for (int i = 0; i < NUM_PIX; i++)  r_pix[i]  <= '0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        c_load: begin
          if (w_meas_fire) begin
            r_bank[r_idx] <= meas_data;
            // A short block ends on meas_last; a full bank ends the block regardless.
            if (meas_last || (r_idx == c_last_meas)) begin
              r_idx   <= '0;
              r_state <= c_start;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        c_start: begin
          r_cnt   <= '0;
          r_state <= c_wait;
        end
        c_wait: begin
          // Done is tested first so it wins over a coincident timeout.
          if (recons_done) begin
            for (int i = 0; i < NUM_PIX; i++) r_pix[i] <= pix_bank[i*PIX_W +: PIX_W];
            r_pidx  <= '0;
            r_state <= c_drain;
          end else if (r_cnt == c_cnt_max) begin
            r_err   <= 1'b1;
            r_idx   <= '0;
            r_state <= c_load;
            for (int i = 0; i < NUM_MEAS; i++) r_bank[i] <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_drain: begin
          if (w_pix_fire) begin
            if (r_pidx == c_last_pix) begin
              r_block_count <= r_block_count + 16'd1;
              r_pidx        <= '0;
              r_idx         <= '0;
              r_state       <= c_load;
              // Clearing here is what zero-fills the next short block.
              for (int i = 0; i < NUM_MEAS; i++) r_bank[i] <= '0;
            end else begin
              r_pidx <= r_pidx + 1'b1;
            end
          end
        end
        default: r_state <= c_load;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_recons_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_recons_block_scheduler
// Description : Self-checking bench for recons_block_scheduler. A block-level
//               reference (expected bank contents, expected pixel sequence,
//               expected cycle positions of start/done/drain) is built from
//               the block rules and compared against the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_recons_block_scheduler;

  localparam int NUM_MEAS = 48;
  localparam int MEAS_W   = 16;
  localparam int NUM_PIX  = 64;
  localparam int PIX_W    = 8;
  localparam int TIMEOUT  = 16;
  localparam int BW       = NUM_MEAS * MEAS_W;

  typedef logic [BW-1:0] chk_t;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     meas_valid = 1'b0;
  logic                     meas_ready;
  logic [MEAS_W-1:0]        meas_data = '0;
  logic                     meas_last = 1'b0;
  logic [BW-1:0]            meas_bank;
  logic                     recons_start;
  logic                     recons_done = 1'b0;
  logic [NUM_PIX*PIX_W-1:0] pix_bank = '0;
  logic                     pix_valid;
  logic                     pix_ready = 1'b0;
  logic [PIX_W-1:0]         pix_data;
  logic                     pix_last;
  logic [15:0]              block_count;
  logic                     busy;
  logic                     err_timeout;

  recons_block_scheduler #(
    .NUM_MEAS(NUM_MEAS), .MEAS_W(MEAS_W), .NUM_PIX(NUM_PIX),
    .PIX_W(PIX_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .meas_valid(meas_valid), .meas_ready(meas_ready), .meas_data(meas_data),
    .meas_last(meas_last), .meas_bank(meas_bank),
    .recons_start(recons_start), .recons_done(recons_done), .pix_bank(pix_bank),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_last(pix_last), .block_count(block_count), .busy(busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_blocks = 0;
  logic exp_err = 1'b0;
  logic [MEAS_W-1:0] exp_bank [NUM_MEAS];
  logic [PIX_W-1:0]  exp_pix  [NUM_PIX];

  task automatic check(input string tag, input chk_t got, input chk_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic chk_t flat_bank();
    chk_t f = '0;
    for (int i = 0; i < NUM_MEAS; i++) f[i*MEAS_W +: MEAS_W] = exp_bank[i];
    return f;
  endfunction

  // Runs one block. done_dly < 0 means the core never answers; mode 0 = no
  // output stalls, 1 = alternating ready, 2 = random ready and input gaps.
  // abort_at >= 0 asserts reset after that many pixels have been drained.
  task automatic run_block(input int nb, input bit use_last, input int done_dly,
                           input int mode, input bit spurious, input int abort_at,
                           input bit fixed);
    int got;
    int cyc;
    logic [MEAS_W-1:0] v;
    for (int i = 0; i < NUM_MEAS; i++) exp_bank[i] = '0;

    for (int i = 0; i < nb; i++) begin
      if (mode == 2) begin
        int gaps = $urandom_range(0, 2);
        repeat (gaps) begin
          @(negedge clk);
          check("gap_ready", chk_t'(meas_ready), chk_t'(1));
          check("gap_busy", chk_t'(busy), chk_t'(i != 0));
          meas_valid = 1'b0;
          recons_done = spurious;
        end
      end
      @(negedge clk);
      check("load_ready", chk_t'(meas_ready), chk_t'(1));
      check("load_busy", chk_t'(busy), chk_t'(i != 0));
      if (fixed) begin
        case (i)
          0:       v = 16'd6115;
          1:       v = 16'd2363;
          2:       v = 16'd3027;
          15:      v = 16'd3045;
          default: v = MEAS_W'($urandom_range(1, 32));
        endcase
      end else begin
        v = MEAS_W'($urandom);
      end
      exp_bank[i] = v;
      meas_valid  = 1'b1;
      meas_data   = v;
      meas_last   = use_last && (i == nb - 1);
      recons_done = spurious;
    end

    // Cycle after the final accepted beat: start pulse, bank complete.
    @(negedge clk);
    meas_valid = 1'b0;
    meas_last  = 1'b0;
    meas_data  = '0;
    check("start_pulse", chk_t'(recons_start), chk_t'(1));
    check("start_ready", chk_t'(meas_ready), chk_t'(0));
    check("start_bank", chk_t'(meas_bank), flat_bank());
    recons_done = spurious;
    for (int i = 0; i < NUM_PIX; i++) begin
      exp_pix[i] = PIX_W'($urandom_range(0, 255));
      pix_bank[i*PIX_W +: PIX_W] = exp_pix[i];
    end

    if (done_dly < 0) begin
      for (int c = 1; c <= TIMEOUT; c++) begin
        @(negedge clk);
        recons_done = 1'b0;
        check("to_wait_valid", chk_t'(pix_valid), chk_t'(0));
        check("to_wait_err", chk_t'(err_timeout), chk_t'(exp_err));
        check("to_wait_busy", chk_t'(busy), chk_t'(1));
      end
      @(negedge clk);
      exp_err = 1'b1;
      check("to_err", chk_t'(err_timeout), chk_t'(1));
      check("to_busy", chk_t'(busy), chk_t'(0));
      check("to_ready", chk_t'(meas_ready), chk_t'(1));
      check("to_valid", chk_t'(pix_valid), chk_t'(0));
      check("to_bank", chk_t'(meas_bank), chk_t'(0));
      check("to_count", chk_t'(block_count), chk_t'(exp_blocks));
      return;
    end

    for (int c = 1; c < done_dly; c++) begin
      @(negedge clk);
      recons_done = 1'b0;
      check("wait_valid", chk_t'(pix_valid), chk_t'(0));
      check("wait_start", chk_t'(recons_start), chk_t'(0));
      check("wait_ready", chk_t'(meas_ready), chk_t'(0));
    end
    @(negedge clk);
    recons_done = 1'b1;

    @(negedge clk);
    recons_done = 1'b0;
    // Scramble the core outputs: the drained pixels must come from the snapshot.
    for (int i = 0; i < NUM_PIX; i++) pix_bank[i*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 255));
    meas_valid = 1'b1;
    meas_data  = MEAS_W'($urandom);
    got = 0;
    cyc = 0;
    while (got < NUM_PIX && cyc < 400) begin
      check("drain_valid", chk_t'(pix_valid), chk_t'(1));
      check("drain_data", chk_t'(pix_data), chk_t'(exp_pix[got]));
      check("drain_last", chk_t'(pix_last), chk_t'(got == NUM_PIX - 1));
      check("drain_ready", chk_t'(meas_ready), chk_t'(0));
      check("drain_bank", chk_t'(meas_bank), flat_bank());
      if (abort_at >= 0 && got == abort_at) begin
        reset = 1'b0;
        #1;
        exp_blocks = 0;
        exp_err = 1'b0;
        check("rst_valid", chk_t'(pix_valid), chk_t'(0));
        check("rst_count", chk_t'(block_count), chk_t'(0));
        check("rst_bank", chk_t'(meas_bank), chk_t'(0));
        check("rst_busy", chk_t'(busy), chk_t'(0));
        check("rst_ready", chk_t'(meas_ready), chk_t'(0));
        check("rst_err", chk_t'(err_timeout), chk_t'(0));
        meas_valid = 1'b0;
        pix_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hold_valid", chk_t'(pix_valid), chk_t'(0));
        reset = 1'b1;
        @(negedge clk);
        check("rel_ready", chk_t'(meas_ready), chk_t'(1));
        check("rel_valid", chk_t'(pix_valid), chk_t'(0));
        return;
      end
      if (mode == 0)      pix_ready = 1'b1;
      else if (mode == 1) pix_ready = (cyc % 2 == 0);
      else                pix_ready = 1'($urandom_range(0, 1));
      if (pix_ready) got++;
      cyc++;
      @(negedge clk);
    end
    pix_ready  = 1'b0;
    meas_valid = 1'b0;
    check("drain_beats", chk_t'(got), chk_t'(NUM_PIX));
    if (mode == 0) check("drain_cycles", chk_t'(cyc), chk_t'(64));
    if (mode == 1) check("drain_cycles_bp", chk_t'(cyc), chk_t'(127));
    exp_blocks++;
    check("end_count", chk_t'(block_count), chk_t'(exp_blocks));
    check("end_valid", chk_t'(pix_valid), chk_t'(0));
    check("end_busy", chk_t'(busy), chk_t'(0));
    check("end_ready", chk_t'(meas_ready), chk_t'(1));
    check("end_bank", chk_t'(meas_bank), chk_t'(0));
    check("end_err", chk_t'(err_timeout), chk_t'(exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ready", chk_t'(meas_ready), chk_t'(0));
    check("reset_busy", chk_t'(busy), chk_t'(0));
    check("reset_start", chk_t'(recons_start), chk_t'(0));
    check("reset_valid", chk_t'(pix_valid), chk_t'(0));
    check("reset_data", chk_t'(pix_data), chk_t'(0));
    check("reset_last", chk_t'(pix_last), chk_t'(0));
    check("reset_bank", chk_t'(meas_bank), chk_t'(0));
    check("reset_count", chk_t'(block_count), chk_t'(0));
    check("reset_err", chk_t'(err_timeout), chk_t'(0));
    reset = 1'b1;

    run_block(48, 1'b0, 10, 0, 1'b0, -1, 1'b1);   // full block, no stalls
    run_block(16, 1'b1, 10, 0, 1'b0, -1, 1'b1);   // short block, zero fill
    run_block(48, 1'b0, 10, 1, 1'b0, -1, 1'b0);   // alternating backpressure
    run_block(48, 1'b1, -1, 0, 1'b0, -1, 1'b0);   // core never answers
    run_block(20, 1'b1, 10, 2, 1'b0, -1, 1'b0);   // recovery, error stays set
    run_block(30, 1'b1, 5,  0, 1'b1, -1, 1'b0);   // spurious done in LOAD/START
    run_block(10, 1'b1, 16, 0, 1'b0, -1, 1'b0);   // done on the timeout cycle
    run_block(48, 1'b0, 10, 0, 1'b0, 20, 1'b0);   // reset mid-drain
    run_block(1,  1'b1, 3,  2, 1'b0, -1, 1'b0);   // single-beat block
    for (int r = 0; r < 6; r++) begin
      int nb = $urandom_range(1, NUM_MEAS);
      bit ul = (nb < NUM_MEAS) ? 1'b1 : 1'($urandom_range(0, 1));
      run_block(nb, ul, $urandom_range(1, 15), 2, 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
